// File: rtl/axis_pfifo_ram.sv
// Simple dual-port buffer: synchronous write, asynchronous read.
// Kept separate so it can be remapped to LUTRAM or BRAM without touching control.
module axis_pfifo_ram #(
  parameter int WIDTH = 9,
  parameter int ABITS = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ABITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pfifo.sv
// Store-and-forward AXI4-Stream packet FIFO with cut-through release for
// frames that do not fit in the buffer.
module axis_pfifo #(
  parameter int WIDTH = 8,
  parameter int ABITS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic [ABITS:0]   level_o,
  output logic [ABITS:0]   frames_o
);

  // Handshake: a beat moves on either side at a rising edge where valid and
  // ready are both high; valid never waits on ready, and the output register
  // holds data and last stable while valid is high and ready is low.

  localparam logic [ABITS:0] ONE = 1;

  logic [ABITS:0] wr_ptr;
  logic [ABITS:0] rd_ptr;
  logic [ABITS:0] frames_q;
  logic           ready_q;
  logic           release_q;
  logic           empty;
  logic           full;
  logic           wr_en;
  logic           ld;
  logic           frame_in;
  logic           frame_out;
  logic [WIDTH:0] rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ABITS] != rd_ptr[ABITS]) &&
                 (wr_ptr[ABITS-1:0] == rd_ptr[ABITS-1:0]);

  // ready_q keeps the input closed during reset and opens it one edge later.
  assign s_tready_o = ready_q && !full;
  assign wr_en      = s_tvalid_i && s_tready_o;
  assign ld         = !empty && ((frames_q != '0) || release_q) &&
                      (!m_tvalid_o || m_tready_i);
  assign frame_in   = wr_en && s_tlast_i;
  assign frame_out  = ld && rd_word[WIDTH];

  assign level_o  = wr_ptr - rd_ptr;
  assign frames_o = frames_q;

  axis_pfifo_ram #(
    .WIDTH(WIDTH + 1),
    .ABITS(ABITS)
  ) u_ram (
    .clock(clock),
    .we   (wr_en),
    .waddr(wr_ptr[ABITS-1:0]),
    .wdata({s_tlast_i, s_tdata_i}),
    .raddr(rd_ptr[ABITS-1:0]),
    .rdata(rd_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frames_q   <= '0;
      ready_q    <= 1'b0;
      release_q  <= 1'b0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tdata_o  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + ONE;

      if (ld) begin
        rd_ptr     <= rd_ptr + ONE;
        m_tvalid_o <= 1'b1;
        m_tlast_o  <= rd_word[WIDTH];
        m_tdata_o  <= rd_word[WIDTH-1:0];
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end

      case ({frame_in, frame_out})
        2'b10:   frames_q <= frames_q + ONE;
        2'b01:   frames_q <= frames_q - ONE;
        default: frames_q <= frames_q;
      endcase

      // A full buffer with no complete frame can only drain by cut-through.
      if (frame_out)                      release_q <= 1'b0;
      else if (full && frames_q == '0)    release_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_pfifo.sv
// Directed bench for axis_pfifo (WIDTH=8, ABITS=3) with a decoupled scoreboard.
module tb_axis_pfifo;

  localparam int WIDTH = 8;
  localparam int ABITS = 3;

  logic             clock;
  logic             reset;
  logic             s_tvalid_i;
  logic             s_tready_o;
  logic             s_tlast_i;
  logic [WIDTH-1:0] s_tdata_i;
  logic             m_tvalid_o;
  logic             m_tready_i;
  logic             m_tlast_o;
  logic [WIDTH-1:0] m_tdata_o;
  logic [ABITS:0]   level_o;
  logic [ABITS:0]   frames_o;

  logic [WIDTH:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  axis_pfifo #(.WIDTH(WIDTH), .ABITS(ABITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .s_tvalid_i(s_tvalid_i),
    .s_tready_o(s_tready_o),
    .s_tlast_i (s_tlast_i),
    .s_tdata_i (s_tdata_i),
    .m_tvalid_o(m_tvalid_o),
    .m_tready_i(m_tready_i),
    .m_tlast_o (m_tlast_o),
    .m_tdata_o (m_tdata_o),
    .level_o   (level_o),
    .frames_o  (frames_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver: present one beat and hold it until accepted
  task automatic push_beat(input logic [WIDTH-1:0] d, input logic l);
    bit done = 0;
    s_tvalid_i = 1'b1;
    s_tdata_i  = d;
    s_tlast_i  = l;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clock);
      if (s_tready_o) begin
        exp_q.push_back({l, d});
        @(posedge clock);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL push_timeout: beat %0h not accepted, required acceptance within 100 cycles", d);
    end
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  // checks a gap-free run of n beats starting now, data base+i
  task automatic stream_check(input string nm, input logic [WIDTH-1:0] base, input int n,
                              input logic [31:0] last_mask);
    for (int i = 0; i < n; i++) begin
      check({nm, "_valid"}, m_tvalid_o, 1);
      check({nm, "_data"}, m_tdata_o, base + WIDTH'(i));
      check({nm, "_last"}, m_tlast_o, last_mask[i]);
      if (i < n - 1) tick();
    end
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic           stall;
    logic [WIDTH:0] held;
    logic [WIDTH:0] w;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        check("frames_le_level", frames_o <= level_o, 1);
        if (stall && m_tvalid_o)
          check("stall_stable", {m_tlast_o, m_tdata_o}, held);
        if (m_tvalid_o && m_tready_i) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL sb_unexpected: got beat %0h, expected no beat", {m_tlast_o, m_tdata_o});
          end else begin
            w = exp_q.pop_front();
            check("sb_beat", {m_tlast_o, m_tdata_o}, w);
          end
        end
        stall = m_tvalid_o && !m_tready_i;
        held  = {m_tlast_o, m_tdata_o};
      end
    end
  end

  initial begin : stimulus
    int gaps [4] = '{2, 0, 3, 1};
    bit seen;
    reset      = 1'b1;
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    s_tdata_i  = '0;
    m_tready_i = 1'b0;

    // reset state
    #3;
    check("rst_tready", s_tready_o, 0);
    check("rst_tvalid", m_tvalid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_frames", frames_o, 0);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_tready_hold", s_tready_o, 0);
    tick();
    check("tready_open", s_tready_o, 1);

    // single 5-beat frame
    m_tready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_beat(8'h11 + 8'(i), 1'b0);
      check("f1_hold", m_tvalid_o, 0);
      check("f1_frames0", frames_o, 0);
    end
    push_beat(8'h15, 1'b1);
    check("f1_frames1", frames_o, 1);
    check("f1_notyet", m_tvalid_o, 0);
    tick();
    stream_check("f1", 8'h11, 5, 32'h10);
    check("f1_frames_end", frames_o, 0);
    tick();
    check("f1_idle", m_tvalid_o, 0);

    // 4-beat frame with input gaps
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) tick();
      push_beat(8'h21 + 8'(i), i == 3);
      if (i < 3) check("f2_hold", m_tvalid_o, 0);
    end
    tick();
    stream_check("f2", 8'h21, 4, 32'h8);
    tick();

    // two 3-beat frames stored behind a stalled sink; first beat parks in the output register
    m_tready_i = 1'b0;
    for (int i = 0; i < 6; i++) push_beat(8'h31 + 8'(i), (i == 2) || (i == 5));
    check("f3_frames", frames_o, 2);
    check("f3_level", level_o, 5);
    m_tready_i = 1'b1;
    stream_check("f3", 8'h31, 6, 32'h24);
    check("f3_frames_end", frames_o, 0);
    tick();

    // 12-beat frame exceeding the buffer: overflow release
    for (int i = 0; i < 8; i++) push_beat(8'h41 + 8'(i), 1'b0);
    check("ovf_level", level_o, 8);
    check("ovf_tready", s_tready_o, 0);
    check("ovf_nostream", m_tvalid_o, 0);
    tick();
    check("ovf_release_set", dut.release_q, 1);
    for (int i = 8; i < 12; i++) push_beat(8'h41 + 8'(i), i == 11);
    seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      tick();
      if (m_tvalid_o && m_tlast_o) seen = 1;
    end
    check("ovf_last_seen", seen, 1);
    check("ovf_release_clr", dut.release_q, 0);
    check("ovf_frames", frames_o, 0);
    repeat (3) tick();

    // full buffer, then drain with ready toggling
    m_tready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(8'h51 + 8'(i), i == 3);
    for (int i = 0; i < 5; i++) push_beat(8'h55 + 8'(i), i == 4);
    check("full_level", level_o, 8);
    check("full_frames", frames_o, 2);
    check("full_tready", s_tready_o, 0);
    check("full_out", m_tdata_o, 8'h51);
    m_tready_i = 1'b1;
    tick();
    check("full_tready_back", s_tready_o, 1);
    check("full_level7", level_o, 7);
    check("full_out2", m_tdata_o, 8'h52);
    for (int n = 0; n < 40 && (exp_q.size() != 0 || m_tvalid_o); n++) begin
      m_tready_i = ~m_tready_i;
      tick();
    end
    check("full_drained", exp_q.size(), 0);
    m_tready_i = 1'b1;
    tick();

    // reset mid-frame
    for (int i = 0; i < 3; i++) push_beat(8'h71 + 8'(i), 1'b0);
    check("mid_level", level_o, 3);
    reset = 1'b1;
    #1;
    check("mrst_tvalid", m_tvalid_o, 0);
    check("mrst_level", level_o, 0);
    check("mrst_frames", frames_o, 0);
    check("mrst_tready", s_tready_o, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    push_beat(8'h81, 1'b0);
    push_beat(8'h82, 1'b1);
    tick();
    stream_check("mrst_frame", 8'h81, 2, 32'h2);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    repeat (3) tick();
    check("final_empty", exp_q.size(), 0);
    check("final_level", level_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
